// File: rtl/clk_enable_nco_if.sv
// Control/status bundle for clk_enable_nco.
// Write port: wr_en is a single-cycle strobe with no ready; the NCO accepts every
// strobe on the edge it is sampled, and wr_ch >= NUM_CH is dropped without effect.
// Outputs are registered and valid every cycle after reset; lock_state mirrors the
// lock FSM (0 = SETTLING, 1 = LOCKED) for observation.
interface clk_enable_nco_if #(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 24
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic              wr_en;
  logic [CHW-1:0]    wr_ch;
  logic [ACC_W-1:0]  wr_inc;
  logic [NUM_CH-1:0] ce_out;
  logic [NUM_CH-1:0] clk_out;
  logic              locked;
  logic              lock_state;

  modport master (
    output enable, wr_en, wr_ch, wr_inc,
    input  ce_out, clk_out, locked, lock_state
  );

  modport slave (
    input  enable, wr_en, wr_ch, wr_inc,
    output ce_out, clk_out, locked, lock_state
  );
endinterface

// File: rtl/clk_enable_nco.sv
// Multi-channel phase-accumulator NCO producing clock-enable strobes and divided
// clocks from the system clock, with a lock flag that reports when all channels
// have run undisturbed for LOCK_CYCLES enabled cycles.
module clk_enable_nco #(
  parameter int               NUM_CH      = 3,
  parameter int               ACC_W       = 24,
  parameter logic [ACC_W-1:0] INC_DEFAULT = 24'h555555,
  parameter int               LOCK_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  clk_enable_nco_if.slave   bus
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  localparam logic [0:0] ST_SETTLING = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [ACC_W-1:0]  r_inc [NUM_CH];
  logic [ACC_W:0]    w_sum [NUM_CH];
  logic [NUM_CH-1:0] r_ce;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] w_wr_hit;
  logic              w_wr_valid;
  logic [LCW-1:0]    r_lock_cnt;
  logic [LCW-1:0]    w_cnt_next;
  logic [0:0]        r_state;

  // A write addresses a real channel only when wr_ch is in range.
  assign w_wr_valid = bus.wr_en &&
                      ({{(32-CHW){1'b0}}, bus.wr_ch} < 32'(NUM_CH));

  // Per-channel next accumulator value with carry and write-select decode.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      if (w_wr_valid && (bus.wr_ch == CHW'(i))) w_wr_hit[i] = 1'b1;
    end
  end

  // Accumulate, strobe on carry, toggle divided clock; a write restarts its channel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        r_acc[i] <= '0;
        r_inc[i] <= INC_DEFAULT;
        r_ce[i]  <= 1'b0;
        r_clk[i] <= 1'b0;
      end else if (w_wr_hit[i]) begin
        r_acc[i] <= '0;
        r_inc[i] <= bus.wr_inc;
        r_ce[i]  <= 1'b0;
        r_clk[i] <= 1'b0;
      end else if (bus.enable) begin
        r_acc[i] <= w_sum[i][ACC_W-1:0];
        r_ce[i]  <= w_sum[i][ACC_W];
        r_clk[i] <= r_clk[i] ^ w_sum[i][ACC_W];
      end else begin
        r_ce[i]  <= 1'b0;
      end
    end
  end

  // Saturating count of undisturbed enabled cycles.
  assign w_cnt_next = (r_lock_cnt == LCW'(LOCK_CYCLES)) ? r_lock_cnt
                                                        : r_lock_cnt + 1'b1;

  // Lock FSM: any valid write drops back to SETTLING, even on the completing edge.
  always_ff @(posedge clk) begin
    if (reset || w_wr_valid) begin
      r_lock_cnt <= '0;
      r_state    <= ST_SETTLING;
    end else if (bus.enable) begin
      r_lock_cnt <= w_cnt_next;
      r_state    <= (w_cnt_next == LCW'(LOCK_CYCLES)) ? ST_LOCKED : ST_SETTLING;
    end
  end

  assign bus.ce_out     = r_ce;
  assign bus.clk_out    = r_clk;
  assign bus.locked     = (r_state == ST_LOCKED);
  assign bus.lock_state = r_state;
endmodule
